smart_led_frame_select: RTL and testbench

//  Parametrised frame selector for the smart-LED serial chain. It sits between the Manchester decoder and the forwarding

---
 rtl/smart_led_frame_select.sv | 137 +++++++++++++
 tb/tb_smart_led_frame_select.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_led_frame_select.sv
// Smart-LED chain frame selector: counts decoded bits into frames, claims free
// frames for local LED channels and marks them taken before forwarding them downstream.
module smart_led_frame_select #(
    parameter int FRAME_BITS = 32,
    parameter int NUM_CH     = 2,
    localparam int CW        = $clog2(NUM_CH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_data,
    input  logic                  in_clk,
    input  logic                  in_sync,
    input  logic [CW-1:0]         ch_count,
    output logic                  out_data,
    output logic                  out_clk,
    output logic [FRAME_BITS-3:0] frame_data,
    output logic [CW-1:0]         frame_ch,
    output logic                  frame_valid,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            state
);

    localparam int PW = FRAME_BITS - 2;
    localparam int BW = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLAIM = 2'd1,
        S_PASS  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   bit_cnt;
    logic            par;
    logic [CW-1:0]   ch;
    logic [CW-1:0]   n_req;
    logic [PW-1:0]   payload_sr;
    logic            first_bit;
    logic            last_bit;
    logic            inv;

    // A request of zero still claims one frame; larger requests saturate at NUM_CH.
    function automatic logic [CW-1:0] clamp_ch(input logic [CW-1:0] c);
        if (c == '0)
            return CW'(1);
        if (int'(c) > NUM_CH)
            return CW'(NUM_CH);
        return c;
    endfunction

    assign first_bit = (bit_cnt == '0);
    assign last_bit  = (bit_cnt == BW'(FRAME_BITS - 1));

    // Clearing the free flag and flipping parity together keeps the frame's even parity intact.
    assign inv = (first_bit && in_data && (state_q == S_IDLE || state_q == S_CLAIM))
              || (last_bit && state_q == S_CLAIM);

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt     <= '0;
            par         <= 1'b0;
            ch          <= '0;
            n_req       <= '0;
            out_data    <= 1'b0;
            out_clk     <= 1'b0;
            frame_data  <= '0;
            frame_ch    <= '0;
            frame_valid <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else if (!in_sync) begin
            state_q     <= S_IDLE;
            bit_cnt     <= '0;
            par         <= 1'b0;
            ch          <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_valid <= 1'b0;
            out_data    <= in_data;
            out_clk     <= in_clk;
        end else if (!in_clk) begin
            out_clk     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            out_clk     <= ~error;
            out_data    <= in_data ^ inv;
            bit_cnt     <= last_bit ? '0 : bit_cnt + BW'(1);

            if (first_bit)
                par <= in_data;
            else if (!last_bit)
                par <= par ^ in_data;

            if (!first_bit && !last_bit)
                payload_sr <= {payload_sr[PW-2:0], in_data};

            // A parity failure overrides any frame completion on the same bit.
            if (last_bit && (par != in_data)) begin
                error   <= 1'b1;
                state_q <= S_ERR;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (first_bit && in_data) begin
                            n_req   <= clamp_ch(ch_count);
                            ch      <= '0;
                            state_q <= S_CLAIM;
                        end
                    end
                    S_CLAIM: begin
                        if (first_bit && !in_data) begin
                            error   <= 1'b1;
                            state_q <= S_ERR;
                        end else if (last_bit) begin
                            frame_data  <= payload_sr;
                            frame_ch    <= ch;
                            frame_valid <= 1'b1;
                            ch          <= ch + CW'(1);
                            if (ch + CW'(1) == n_req) begin
                                state_q <= S_PASS;
                                done    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_smart_led_frame_select.sv
// Randomised and directed bench for smart_led_frame_select, checked against a frame-level model.
module tb_smart_led_frame_select;

    localparam int FB = 32;
    localparam int NC = 2;
    localparam int CW = 2;
    localparam logic [31:0] CLAIM_MASK = 32'h8000_0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_data = 1'b0;
    logic          in_clk = 1'b0;
    logic          in_sync = 1'b0;
    logic [CW-1:0] ch_count = '0;
    logic          out_data, out_clk, frame_valid, done, error;
    logic [FB-3:0] frame_data;
    logic [CW-1:0] frame_ch;
    logic [1:0]    state;

    smart_led_frame_select #(.FRAME_BITS(FB), .NUM_CH(NC)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk), .in_sync(in_sync),
        .ch_count(ch_count), .out_data(out_data), .out_clk(out_clk), .frame_data(frame_data),
        .frame_ch(frame_ch), .frame_valid(frame_valid), .done(done), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Frame-level reference: bits of the current frame kept in an array.
    int          m_state, m_pos, m_nreq, m_nclaimed;
    logic        m_bits [FB];
    logic        m_cur_claimed;
    logic        m_err, m_done, m_fv, m_od, m_oc;
    logic [29:0] m_fd;
    int          m_fch;

    int   fv_count;
    int   fv_ch_q[$];
    logic fwd_q[$];
    int   oclk_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_req(input int c);
        if (c == 0) return 1;
        if (c > NC) return NC;
        return c;
    endfunction

    task automatic model_update(input logic r, input logic s, input logic c, input logic d);
        logic par_bad, claim_now, flip;
        logic [29:0] pl;
        if (!r) begin
            m_state = 0; m_pos = 0; m_nreq = 0; m_nclaimed = 0; m_cur_claimed = 0;
            m_err = 0; m_done = 0; m_fv = 0; m_od = 0; m_oc = 0; m_fd = '0; m_fch = 0;
        end else if (!s) begin
            m_state = 0; m_pos = 0; m_nclaimed = 0; m_err = 0; m_done = 0; m_fv = 0;
            m_od = d; m_oc = c;
        end else if (!c) begin
            m_oc = 0; m_fv = 0;
        end else begin
            m_fv = 0;
            m_oc = !m_err;
            m_bits[m_pos] = d;
            claim_now = (m_pos == 0) && d && (m_state == 0 || m_state == 1);
            if (m_pos == 0) m_cur_claimed = claim_now;
            flip = claim_now || (m_pos == FB - 1 && m_cur_claimed);
            m_od = d ^ flip;
            par_bad = 1'b0;
            if (m_pos == FB - 1)
                for (int i = 0; i < FB; i++) par_bad ^= m_bits[i];
            if (par_bad) begin
                m_err = 1; m_state = 3;
            end else if (m_pos == 0 && m_state == 0 && d) begin
                m_nreq = clamp_req(int'(ch_count)); m_nclaimed = 0; m_state = 1;
            end else if (m_pos == 0 && m_state == 1 && !d) begin
                m_err = 1; m_state = 3;
            end else if (m_pos == FB - 1 && m_state == 1) begin
                pl = '0;
                for (int i = 1; i <= FB - 2; i++) pl = {pl[28:0], m_bits[i]};
                m_fd = pl; m_fch = m_nclaimed; m_fv = 1;
                m_nclaimed++;
                if (m_nclaimed == m_nreq) begin m_state = 2; m_done = 1; end
            end
            m_pos = (m_pos == FB - 1) ? 0 : m_pos + 1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic c, input logic d);
        rst_n = r; in_sync = s; in_clk = c; in_data = d;
        @(posedge clk);
        #1;
        model_update(r, s, c, d);
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_clk", 32'(out_clk), 32'(m_oc));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_data", 32'(frame_data), 32'(m_fd));
        chk("frame_ch", 32'(frame_ch), 32'(m_fch));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("state", 32'(state), 32'(m_state));
        if (frame_valid) begin fv_count++; fv_ch_q.push_back(int'(frame_ch)); end
        if (out_clk) begin fwd_q.push_back(out_data); oclk_cnt++; end
    endtask

    function automatic logic [31:0] mk_frame(input logic free, input logic [29:0] pl, input logic bad);
        logic [31:0] f;
        f[0] = free;
        for (int i = 1; i <= 30; i++) f[i] = pl[30 - i];
        f[31] = (^f[30:0]) ^ bad;
        return f;
    endfunction

    task automatic send_frame(input logic [31:0] f, input int drop_at, input int gap);
        for (int i = 0; i < FB; i++) begin
            if (i == drop_at) begin
                step(1, 0, 1'($urandom), 1'($urandom));
                return;
            end
            step(1, 1, 1, f[i]);
            for (int g = 0; g < gap; g++) step(1, 1, 0, 1'($urandom));
        end
    endtask

    task automatic resync();
        step(1, 0, 0, 0);
        fwd_q.delete();
        fv_ch_q.delete();
        fv_count = 0;
        oclk_cnt = 0;
    endtask

    function automatic logic [31:0] fwd_word(input int base);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = (base + i < fwd_q.size()) ? fwd_q[base + i] : 1'bx;
        return w;
    endfunction

    logic [31:0] f0, f1, f2;

    initial begin
        fv_count = 0; oclk_cnt = 0;
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outclk", 32'(out_clk), 32'd0);
        chk("reset_error", 32'(error), 32'd0);

        // Single claim with ch_count=1
        resync();
        ch_count = 2'd1;
        f0 = mk_frame(1, 30'h2AAAAAAA, 0);
        send_frame(f0, -1, 1);
        step(1, 1, 0, 0);
        chk("t1_pulses", 32'(fv_count), 32'd1);
        chk("t1_data", 32'(frame_data), 32'h2AAAAAAA);
        chk("t1_ch", 32'(frame_ch), 32'd0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_fwd", fwd_word(0), f0 ^ CLAIM_MASK);

        // Two claims, third frame passes bit-exact
        resync();
        ch_count = 2'd2;
        f0 = mk_frame(1, 30'h1, 0);
        f1 = mk_frame(1, 30'h3FFFFFFF, 0);
        f2 = mk_frame(1, 30'(($urandom)), 0);
        send_frame(f0, -1, 0);
        chk("t2_data0", 32'(frame_data), 32'h1);
        send_frame(f1, -1, 2);
        chk("t2_data1", 32'(frame_data), 32'h3FFFFFFF);
        send_frame(f2, -1, 0);
        chk("t2_pulses", 32'(fv_count), 32'd2);
        chk("t2_ch0", 32'(fv_ch_q.size() > 0 ? fv_ch_q[0] : -1), 32'd0);
        chk("t2_ch1", 32'(fv_ch_q.size() > 1 ? fv_ch_q[1] : -1), 32'd1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_fwd2", fwd_word(64), f2);

        // Second frame already taken during claim
        resync();
        ch_count = 2'd2;
        send_frame(mk_frame(1, 30'h155, 0), -1, 0);
        send_frame(mk_frame(0, 30'h2AB, 0), -1, 0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_state", 32'(state), 32'd3);
        oclk_cnt = 0;
        send_frame(mk_frame(1, 30'h77, 0), -1, 1);
        chk("t3_quiet", 32'(oclk_cnt), 32'd0);
        chk("t3_pulses", 32'(fv_count), 32'd1);

        // Taken frame passes unchanged, next free frame is claimed
        resync();
        ch_count = 2'd1;
        f0 = mk_frame(0, 30'h1234567, 0);
        f1 = mk_frame(1, 30'h0ABCDEF, 0);
        send_frame(f0, -1, 0);
        send_frame(f1, -1, 0);
        chk("t4_fwd0", fwd_word(0), f0);
        chk("t4_fwd1", fwd_word(32), f1 ^ CLAIM_MASK);
        chk("t4_data", 32'(frame_data), 32'h0ABCDEF);

        // Bad parity in IDLE, then recovery after one-cycle sync drop
        resync();
        ch_count = 2'd1;
        send_frame(mk_frame(0, 30'h3, 1), -1, 0);
        chk("t5_error", 32'(error), 32'd1);
        resync();
        chk("t5_clear", 32'(error), 32'd0);
        chk("t5_idle", 32'(state), 32'd0);
        send_frame(mk_frame(1, 30'h2468ACE, 0), -1, 0);
        chk("t5_claim", 32'(fv_count), 32'd1);
        chk("t5_data", 32'(frame_data), 32'h2468ACE);

        // Sync drop mid claimed frame, then transparent forwarding
        resync();
        ch_count = 2'd1;
        send_frame(mk_frame(1, 30'h1357, 0), 15, 0);
        chk("t6_nopulse", 32'(fv_count), 32'd0);
        chk("t6_state", 32'(state), 32'd0);
        step(1, 0, 1, 1);
        chk("t6_tr_data1", 32'(out_data), 32'd1);
        chk("t6_tr_clk1", 32'(out_clk), 32'd1);
        step(1, 0, 0, 0);
        chk("t6_tr_data0", 32'(out_data), 32'd0);
        chk("t6_tr_clk0", 32'(out_clk), 32'd0);
        for (int i = 0; i < 20; i++) step(1, 0, 1'($urandom), 1'($urandom));

        // Random traffic across many sync periods
        for (int k = 0; k < 60; k++) begin
            ch_count = CW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    step(1, 0, 1'($urandom), 1'($urandom));
            send_frame(mk_frame(1'($urandom_range(0, 2) != 0), 30'($urandom),
                                1'($urandom_range(0, 7) == 0)),
                       ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 31)) : -1,
                       int'($urandom_range(0, 2)));
        end
        step(1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
